// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: one bit per clock,
// shift-add multiply and restoring divide over a shared 2*WIDTH accumulator.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  input  logic             hiWrite,
  input  logic             loWrite,
  input  logic [WIDTH-1:0] writeValue,
  output logic             busy,
  output logic             done,
  output logic             divByZero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(0);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [1:0]           op_q, op_d;
  logic [WIDTH-1:0]     opnd_q, opnd_d;
  logic [WIDTH-1:0]     a_orig_q, a_orig_d;
  logic                 neg_q_q, neg_q_d;
  logic                 neg_r_q, neg_r_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic                 busy_q, busy_d, done_q, done_d, dbz_q, dbz_d;

  logic                 signed_op_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH-1:0]     mul_add_s;
  logic [WIDTH:0]       mul_sum_s, div_shift_s, div_diff_s;
  logic [2*WIDTH-1:0]   acc_step_s, prod_fix_s;
  logic [WIDTH-1:0]     quo_s, rem_s, quo_fix_s, rem_fix_s;

  function automatic logic [WIDTH-1:0] mag_of(input logic [WIDTH-1:0] v, input logic sgn);
    if (sgn && v[WIDTH-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  // Operand magnitudes as they would be latched on an accepted start.
  always_comb begin
    signed_op_s = ~op[0];
    a_mag_s     = mag_of(operandA, signed_op_s);
    b_mag_s     = mag_of(operandB, signed_op_s);
  end

  // One iteration of the datapath plus sign-corrected final results.
  // Multiply: acc = {partial, multiplier}; divide: acc = {remainder, dividend/quotient}.
  always_comb begin
    mul_add_s   = acc_q[0] ? opnd_q : {WIDTH{1'b0}};
    mul_sum_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_add_s};
    div_shift_s = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff_s  = div_shift_s - {1'b0, opnd_q};
    if (op_q[1]) begin
      if (div_diff_s[WIDTH]) begin
        acc_step_s = {div_shift_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end else begin
        acc_step_s = {div_diff_s[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_step_s = {mul_sum_s, acc_q[WIDTH-1:1]};
    end
    quo_s      = acc_step_s[WIDTH-1:0];
    rem_s      = acc_step_s[2*WIDTH-1:WIDTH];
    quo_fix_s  = neg_q_q ? -quo_s : quo_s;
    rem_fix_s  = neg_r_q ? -rem_s : rem_s;
    prod_fix_s = neg_q_q ? -acc_step_s : acc_step_s;
  end

  // Next-state logic for the IDLE/RUN controller and HI/LO registers.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    opnd_d   = opnd_q;
    a_orig_d = a_orig_q;
    neg_q_d  = neg_q_q;
    neg_r_d  = neg_r_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dbz_d    = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          op_d     = op;
          a_orig_d = operandA;
          neg_q_d  = signed_op_s & (operandA[WIDTH-1] ^ operandB[WIDTH-1]);
          neg_r_d  = signed_op_s & operandA[WIDTH-1];
          dbz_d    = 1'b0;
          cnt_d    = CNT_LAST;
          busy_d   = 1'b1;
          state_d  = RUN;
          if (op[1]) begin
            opnd_d = b_mag_s;
            acc_d  = {{WIDTH{1'b0}}, a_mag_s};
          end else begin
            opnd_d = a_mag_s;
            acc_d  = {{WIDTH{1'b0}}, b_mag_s};
          end
        end else begin
          if (hiWrite) begin
            hi_d = writeValue;
          end else begin
            hi_d = hi_q;
          end
          if (loWrite) begin
            lo_d = writeValue;
          end else begin
            lo_d = lo_q;
          end
        end
      end
      RUN: begin
        acc_d = acc_step_s;
        if (cnt_q == CNT_ZERO) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
          if (!op_q[1]) begin
            hi_d = prod_fix_s[2*WIDTH-1:WIDTH];
            lo_d = prod_fix_s[WIDTH-1:0];
          end else if (opnd_q == {WIDTH{1'b0}}) begin
            // Divide by zero reports the untouched dividend in HI.
            hi_d  = a_orig_q;
            lo_d  = {WIDTH{1'b1}};
            dbz_d = 1'b1;
          end else begin
            hi_d = rem_fix_s;
            lo_d = quo_fix_s;
          end
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= CNT_ZERO;
      op_q     <= 2'b00;
      opnd_q   <= {WIDTH{1'b0}};
      a_orig_q <= {WIDTH{1'b0}};
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      acc_q    <= {(2*WIDTH){1'b0}};
      hi_q     <= {WIDTH{1'b0}};
      lo_q     <= {WIDTH{1'b0}};
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      opnd_q   <= opnd_d;
      a_orig_q <= a_orig_d;
      neg_q_q  <= neg_q_d;
      neg_r_q  <= neg_r_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign divByZero = dbz_q;
  assign hi        = hi_q;
  assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: cycle-level behavioural model using 64-bit
// arithmetic, per-cycle output comparison, directed literal cases and random ops.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] operandA, operandB, writeValue;
  logic        hiWrite, loWrite;
  logic        busy, done, divByZero;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .operandA(operandA), .operandB(operandB),
    .hiWrite(hiWrite), .loWrite(loWrite), .writeValue(writeValue),
    .busy(busy), .done(done), .divByZero(divByZero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference result {divByZero, hi, lo} straight from the arithmetic rules.
  function automatic logic [64:0] ref_calc(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, sp, sq, sr;
    logic [63:0] up, tmp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: begin
        sp  = sa * sb;
        tmp = sp;
        return {1'b0, tmp};
      end
      2'b01: begin
        up = 64'(a) * 64'(b);
        return {1'b0, up};
      end
      2'b10: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        sq  = sa / sb;
        sr  = sa % sb;
        tmp = {sr[31:0], sq[31:0]};
        return {1'b0, tmp};
      end
      default: begin
        if (b == 32'd0) return {1'b1, a, 32'hFFFF_FFFF};
        return {1'b0, a % b, a / b};
      end
    endcase
  endfunction

  // Behavioural model: expected outputs after each edge.
  logic [31:0] m_hi, m_lo;
  logic        m_busy, m_done, m_dbz;
  int          m_left;
  logic [64:0] m_pend;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_hi <= 32'd0; m_lo <= 32'd0; m_busy <= 1'b0; m_done <= 1'b0; m_dbz <= 1'b0;
      m_left <= 0; m_pend <= 65'd0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (m_left == 1) begin
          m_dbz  <= m_pend[64];
          m_hi   <= m_pend[63:32];
          m_lo   <= m_pend[31:0];
          m_done <= 1'b1;
          m_busy <= 1'b0;
          m_left <= 0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (start) begin
        m_pend <= ref_calc(op, operandA, operandB);
        m_busy <= 1'b1;
        m_left <= 32;
        m_dbz  <= 1'b0;
      end else begin
        if (hiWrite) m_hi <= writeValue;
        if (loWrite) m_lo <= writeValue;
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    check("busy", 64'(busy), 64'(m_busy));
    check("done", 64'(done), 64'(m_done));
    check("divByZero", 64'(divByZero), 64'(m_dbz));
    check("hi", 64'(hi), 64'(m_hi));
    check("lo", 64'(lo), 64'(m_lo));
  end

  task automatic idle(input logic hw, input logic lw, input logic [31:0] val);
    hiWrite = hw; loWrite = lw; writeValue = val;
    @(posedge clk); #1;
    hiWrite = 1'b0; loWrite = 1'b0;
  endtask

  // Issue one op (caller is 1 time unit after an edge) and wait for done.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit noise, input bit hw, input logic [31:0] hold_hi,
                        input bit lit, input logic [31:0] eh, input logic [31:0] el, input logic ed);
    int bc, g;
    start = 1'b1; op = o; operandA = a; operandB = b;
    hiWrite = hw; loWrite = 1'b0; writeValue = 32'h5555_AAAA;
    @(posedge clk); #1;
    start = 1'b0; hiWrite = 1'b0;
    operandA = $urandom; operandB = $urandom;
    check("dbz_clear_at_start", 64'(divByZero), 64'd0);
    check("busy_after_start", 64'(busy), 64'd1);
    if (lit && hw) check("hi_write_discarded", 64'(hi), 64'(hold_hi));
    bc = 0; g = 0;
    while (!done && g < 40) begin
      if (busy) bc++;
      if (noise) begin
        start = 1'($urandom_range(0, 1)); op = 2'($urandom);
        hiWrite = 1'($urandom_range(0, 1)); loWrite = 1'($urandom_range(0, 1));
        writeValue = 32'h0000_1234;
      end
      @(posedge clk); #1;
      start = 1'b0; hiWrite = 1'b0; loWrite = 1'b0;
      g++;
    end
    check("done_within_budget", 64'(done), 64'd1);
    check("busy_cycles", 64'(bc), 64'd32);
    check("busy_clear_at_done", 64'(busy), 64'd0);
    if (lit) begin
      check("lit_hi", 64'(hi), 64'(eh));
      check("lit_lo", 64'(lo), 64'(el));
      check("lit_dbz", 64'(divByZero), 64'(ed));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nidle;
    reset = 1'b1; start = 1'b0; op = 2'b00; operandA = 32'd0; operandB = 32'd0;
    hiWrite = 1'b0; loWrite = 1'b0; writeValue = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dbz", 64'(divByZero), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op(2'b00, 32'hFFFF_FFFD, 32'd5, 0, 0, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b0);
    @(posedge clk); #1;
    check("done_one_cycle", 64'(done), 64'd0);
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 32'd0, 1, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, 0, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 32'd0, 1, 32'd0, 32'h8000_0000, 1'b0);
    run_op(2'b11, 32'd100, 32'd0, 0, 0, 32'd0, 1, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    run_op(2'b01, 32'd2, 32'd3, 0, 0, 32'd0, 1, 32'd0, 32'd6, 1'b0);
    run_op(2'b11, 32'd1000, 32'd7, 1, 0, 32'd0, 1, 32'd6, 32'd142, 1'b0);

    idle(1'b1, 1'b0, 32'h0000_ABCD);
    check("mthi", 64'(hi), 64'h0000_ABCD);
    idle(1'b0, 1'b1, 32'h0000_1234);
    check("mtlo", 64'(lo), 64'h0000_1234);
    check("mtlo_keeps_hi", 64'(hi), 64'h0000_ABCD);
    run_op(2'b01, 32'd2, 32'd3, 0, 1, 32'h0000_ABCD, 1, 32'd0, 32'd6, 1'b0);

    // Asynchronous reset ten cycles into a divide.
    start = 1'b1; op = 2'b11; operandA = 32'hDEAD_BEEF; operandB = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    #2 reset = 1'b1;
    #1;
    check("async_rst_hi", 64'(hi), 64'd0);
    check("async_rst_lo", 64'(lo), 64'd0);
    check("async_rst_busy", 64'(busy), 64'd0);
    check("async_rst_done", 64'(done), 64'd0);
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    for (int k = 0; k < 36; k++) begin
      @(posedge clk); #1;
      check("no_done_after_reset", 64'(done), 64'd0);
    end

    for (int i = 0; i < 40; i++) begin
      nidle = $urandom_range(0, 2);
      for (int j = 0; j < nidle; j++) idle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
      run_op(2'($urandom), pick(), pick(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             32'd0, 0, 32'd0, 32'd0, 1'b0);
    end
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
